writeback_arbiter: RTL and testbench

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/core_pkg.sv | 11 +
 rtl/wb_fifo2w1r.sv | 77 +++++++
 rtl/writeback_arbiter.sv | 76 +++++++
 tb/tb_writeback_arbiter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared writeback types and default widths for the register-file write path.
package core_pkg;
   localparam int ADDR_WIDTH_DEF = 5;
   localparam int DATA_WIDTH_DEF = 32;
   localparam int DEPTH_DEF      = 4;

   typedef struct packed {
      logic [ADDR_WIDTH_DEF-1:0] addr;
      logic [DATA_WIDTH_DEF-1:0] data;
   } wb_entry_t;
endpackage

// File: rtl/wb_fifo2w1r.sv
// Circular write queue accepting up to two pushes (A then B) and one pop per cycle.
module wb_fifo2w1r
   import core_pkg::*;
#(
   parameter int AW    = ADDR_WIDTH_DEF,
   parameter int DW    = DATA_WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = PW + 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      push_a_i,
   input  logic [AW-1:0]             a_addr_i,
   input  logic [DW-1:0]             a_data_i,
   input  logic                      push_b_i,
   input  logic [AW-1:0]             b_addr_i,
   input  logic [DW-1:0]             b_data_i,
   input  logic                      pop_i,
   output logic [AW-1:0]             head_addr_o,
   output logic [DW-1:0]             head_data_o,
   output logic [CW-1:0]             count_o,
   output logic [DEPTH-1:0]          occ_valid_o,
   output logic [DEPTH-1:0][AW-1:0]  occ_addr_o
);
   logic [AW-1:0]    addr_q [DEPTH];
   logic [DW-1:0]    data_q [DEPTH];
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, slot_b;
   logic [CW-1:0]    count_q, count_d;

   // B lands one slot after A when both push, otherwise it takes A's slot.
   always_comb begin
      slot_b   = push_a_i ? wr_ptr_q + PW'(1) : wr_ptr_q;
      wr_ptr_d = wr_ptr_q + PW'(push_a_i) + PW'(push_b_i);
      rd_ptr_d = rd_ptr_q + PW'(pop_i);
      count_d  = count_q + CW'(push_a_i) + CW'(push_b_i) - CW'(pop_i);
      valid_d  = valid_q;
      if (pop_i)    valid_d[rd_ptr_q] = 1'b0;
      if (push_a_i) valid_d[wr_ptr_q] = 1'b1;
      if (push_b_i) valid_d[slot_b]   = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         valid_q  <= valid_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_a_i) begin
         addr_q[wr_ptr_q] <= a_addr_i;
         data_q[wr_ptr_q] <= a_data_i;
      end
      if (push_b_i) begin
         addr_q[slot_b] <= b_addr_i;
         data_q[slot_b] <= b_data_i;
      end
   end

   assign head_addr_o = addr_q[rd_ptr_q];
   assign head_data_o = data_q[rd_ptr_q];
   assign count_o     = count_q;
   assign occ_valid_o = valid_q;

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_occ
      assign occ_addr_o[gi] = addr_q[gi];
   end
endmodule

// File: rtl/writeback_arbiter.sv
// Merges results from two execution pipes into one register-file write port,
// with decode-stage hazard lookup against queued writes.
module writeback_arbiter
   import core_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int DEPTH      = DEPTH_DEF,
   localparam int CW        = $clog2(DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  a_valid,
   input  logic [ADDR_WIDTH-1:0] a_addr,
   input  logic [DATA_WIDTH-1:0] a_data,
   output logic                  a_ready,
   input  logic                  b_valid,
   input  logic [ADDR_WIDTH-1:0] b_addr,
   input  logic [DATA_WIDTH-1:0] b_data,
   output logic                  b_ready,
   output logic                  wr_en,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_WIDTH-1:0] q1_addr,
   input  logic [ADDR_WIDTH-1:0] q2_addr,
   output logic                  q1_pend,
   output logic                  q2_pend,
   output logic [CW-1:0]         count
);
   logic                            a_push, b_push;
   logic [ADDR_WIDTH-1:0]           head_addr;
   logic [DATA_WIDTH-1:0]           head_data;
   logic [DEPTH-1:0]                occ_valid, hit1, hit2;
   logic [DEPTH-1:0][ADDR_WIDTH-1:0] occ_addr;

   // Ready depends only on registered occupancy, so B needs room for A as well.
   assign a_ready = (count < CW'(DEPTH));
   assign b_ready = (count < CW'(DEPTH - 1));

   // Writes to x0 are handshaken but never queued.
   assign a_push = a_valid && a_ready && (a_addr != '0);
   assign b_push = b_valid && b_ready && (b_addr != '0);

   wb_fifo2w1r #(
      .AW    (ADDR_WIDTH),
      .DW    (DATA_WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_a_i    (a_push),
      .a_addr_i    (a_addr),
      .a_data_i    (a_data),
      .push_b_i    (b_push),
      .b_addr_i    (b_addr),
      .b_data_i    (b_data),
      .pop_i       (wr_en),
      .head_addr_o (head_addr),
      .head_data_o (head_data),
      .count_o     (count),
      .occ_valid_o (occ_valid),
      .occ_addr_o  (occ_addr)
   );

   assign wr_en   = (count != '0);
   assign wr_addr = wr_en ? head_addr : '0;
   assign wr_data = wr_en ? head_data : '0;

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
      assign hit1[gi] = occ_valid[gi] && (occ_addr[gi] == q1_addr);
      assign hit2[gi] = occ_valid[gi] && (occ_addr[gi] == q2_addr);
   end

   assign q1_pend = (q1_addr != '0) && (|hit1);
   assign q2_pend = (q2_addr != '0) && (|hit2);
endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench: queue-based reference model plus directed literal checks.
module tb_writeback_arbiter;
   import core_pkg::*;
   localparam int AW = 5, DW = 32, DEPTH = 4, CW = 3;

   logic          clk, rst_n;
   logic          a_valid, b_valid, a_ready, b_ready, wr_en, q1_pend, q2_pend;
   logic [AW-1:0] a_addr, b_addr, wr_addr, q1_addr, q2_addr;
   logic [DW-1:0] a_data, b_data, wr_data;
   logic [CW-1:0] count;

   int errors = 0;
   int checks = 0;
   wb_entry_t q_m[$];

   writeback_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .q1_addr(q1_addr), .q2_addr(q2_addr), .q1_pend(q1_pend), .q2_pend(q2_pend),
      .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Expected outputs follow directly from the contents of the model queue.
   task automatic compare_model();
      int  n;
      logic p1, p2;
      n  = q_m.size();
      p1 = 1'b0;
      p2 = 1'b0;
      foreach (q_m[i]) begin
         if (q1_addr != 0 && q_m[i].addr == q1_addr) p1 = 1'b1;
         if (q2_addr != 0 && q_m[i].addr == q2_addr) p2 = 1'b1;
      end
      chk("wr_en",   wr_en,   n != 0);
      chk("wr_addr", wr_addr, (n != 0) ? q_m[0].addr : 0);
      chk("wr_data", wr_data, (n != 0) ? q_m[0].data : 0);
      chk("count",   count,   n);
      chk("a_ready", a_ready, (DEPTH - n) >= 1);
      chk("b_ready", b_ready, (DEPTH - n) >= 2);
      chk("q1_pend", q1_pend, p1);
      chk("q2_pend", q2_pend, p2);
   endtask

   task automatic step(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd);
      int n;
      logic acc_a, acc_b;
      wb_entry_t e;
      a_valid = av; a_addr = aa; a_data = ad;
      b_valid = bv; b_addr = ba; b_data = bd;
      #1;
      compare_model();
      n     = q_m.size();
      acc_a = av && ((DEPTH - n) >= 1);
      acc_b = bv && ((DEPTH - n) >= 2);
      @(posedge clk);
      if (n != 0) begin
         e = q_m.pop_front();
         $display("t=%0t write addr=%0d data=%08h", $time, e.addr, e.data);
      end
      if (acc_a && aa != 0) begin e.addr = aa; e.data = ad; q_m.push_back(e); end
      if (acc_b && ba != 0) begin e.addr = ba; e.data = bd; q_m.push_back(e); end
      #2;
   endtask

   task automatic idle();
      step(1'b0, '0, '0, 1'b0, '0, '0);
   endtask

   task automatic reset_mid(input string tag);
      rst_n = 1'b0;
      #1;
      chk({tag, "_rst_wr_en"},   wr_en,   0);
      chk({tag, "_rst_count"},   count,   0);
      chk({tag, "_rst_wr_addr"}, wr_addr, 0);
      chk({tag, "_rst_a_ready"}, a_ready, 1);
      chk({tag, "_rst_b_ready"}, b_ready, 1);
      q_m.delete();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      a_valid = 0; a_addr = 0; a_data = 0;
      b_valid = 0; b_addr = 0; b_data = 0;
      q1_addr = 5'd3; q2_addr = 5'd0;
      #12;
      chk("reset_wr_en", wr_en, 0);
      chk("reset_wr_addr", wr_addr, 0);
      chk("reset_wr_data", wr_data, 0);
      chk("reset_count", count, 0);
      chk("reset_a_ready", a_ready, 1);
      chk("reset_b_ready", b_ready, 1);
      chk("reset_q1_pend", q1_pend, 0);
      chk("reset_q2_pend", q2_pend, 0);
      @(negedge clk);
      rst_n = 1'b1;
      q1_addr = 0;

      // single write
      step(1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
      chk("single_wr_en", wr_en, 1);
      chk("single_wr_addr", wr_addr, 5);
      chk("single_wr_data", wr_data, 32'hDEADBEEF);
      idle();
      chk("single_drained", count, 0);

      // dual issue keeps A before B
      step(1, 5'd3, 32'h11, 1, 5'd4, 32'h22);
      chk("dual_first_addr", wr_addr, 3);
      chk("dual_first_data", wr_data, 32'h11);
      idle();
      chk("dual_second_addr", wr_addr, 4);
      chk("dual_second_data", wr_data, 32'h22);
      idle();
      chk("dual_done", wr_en, 0);

      // x0 results are accepted and dropped
      step(1, 5'd0, 32'h55, 0, 0, 0);
      chk("x0_wr_en", wr_en, 0);
      chk("x0_count", count, 0);
      chk("x0_a_ready", a_ready, 1);

      // continuous dual issue: count saturates at DEPTH-1 with B throttled
      for (int i = 0; i < 6; i++) begin
         step(1, AW'(2*i + 1), 32'hA000 + i, 1, AW'(2*i + 2), 32'hB000 + i);
         if (i == 2) begin
            chk("bp_count", count, 3);
            chk("bp_b_ready", b_ready, 0);
            chk("bp_a_ready", a_ready, 1);
         end
      end
      for (int i = 0; i < 6; i++) idle();
      chk("bp_drained", count, 0);

      // hazard lookup
      step(1, 5'd7, 32'h77, 0, 0, 0);
      q1_addr = 5'd7; q2_addr = 5'd0;
      #1;
      chk("haz_q1_pend", q1_pend, 1);
      chk("haz_q2_pend", q2_pend, 0);
      idle();
      chk("haz_q1_after_drain", q1_pend, 0);
      q1_addr = 0;

      // reset with three entries queued
      step(1, 5'd9, 32'h9, 1, 5'd10, 32'hA);
      step(1, 5'd11, 32'hB, 1, 5'd12, 32'hC);
      chk("pre_rst_count", count, 3);
      reset_mid("mid");
      for (int i = 0; i < 3; i++) begin
         idle();
         chk("post_rst_no_write", wr_en, 0);
      end

      // randomized traffic against the queue model
      for (int i = 0; i < 400; i++) begin
         logic [AW-1:0] aa, ba;
         aa = ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom_range(1, 31));
         ba = ($urandom_range(0, 7) == 0) ? AW'(0) : AW'($urandom_range(1, 31));
         if (q_m.size() != 0 && $urandom_range(0, 1) == 1)
            q1_addr = q_m[$urandom_range(0, q_m.size() - 1)].addr;
         else
            q1_addr = AW'($urandom_range(0, 31));
         q2_addr = AW'($urandom_range(0, 31));
         step(1'($urandom_range(0, 1)), aa, $urandom,
              1'($urandom_range(0, 1)), ba, $urandom);
         if ($urandom_range(0, 99) == 0) reset_mid("rand");
      end
      q1_addr = 0; q2_addr = 0;
      for (int i = 0; i < DEPTH + 1; i++) idle();
      chk("final_empty", count, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
